// File: rtl/router_fsm_param.sv
// -----------------------------------------------------------------------------
// router_fsm_param
//
// Control FSM for a 1xN packet router. It sits between the input register
// block and the N output FIFOs. It decodes the header byte, latches the
// destination, and sequences the load, fifo-full, parity and check phases.
// Packets addressed to a non-existent port are streamed through a drop path
// without writing any FIFO. If the destination FIFO is not empty when a
// header arrives, the FSM waits for it to drain. This wait is bounded: after
// WAIT_TIMEOUT cycles the FSM gives up and pulses timeout_err.
//
// Parameters
//   N_PORTS       number of output channels / FIFOs
//   DATA_W        width of data_in; header byte = {payload_len, addr}
//   ADDR_W        width of the address field data_in[ADDR_W-1:0]
//                 (2**ADDR_W >= N_PORTS, ADDR_W < DATA_W)
//   WAIT_TIMEOUT  max cycles spent waiting for an empty FIFO, 0 = forever
//   CNT_W         wait counter width (WAIT_TIMEOUT < 2**CNT_W)
//
// Ports
//   clock          in   1        single clock, posedge
//   reset          in   1        synchronous, active-high
//   pkt_valid      in   1        source packet valid
//   data_in        in   DATA_W   header / payload byte
//   fifo_empty     in   N_PORTS  per-FIFO empty flags
//   fifo_full      in   1        full flag of the currently selected FIFO
//   soft_reset     in   N_PORTS  per-FIFO read-timeout soft reset
//   low_pkt_valid  in   1        registered pkt_valid low (register block)
//   parity_done    in   1        parity byte captured (register block)
//   dest_addr      out  ADDR_W   latched destination / FIFO select
//   detect_add     out  1        state == DECODE
//   lfd_state      out  1        state == LFD (load first data = header)
//   ld_state       out  1        state == LOAD_DATA
//   full_state     out  1        state == FIFO_FULL
//   laf_state      out  1        state == LAF (load after full)
//   drop_state     out  1        state is DROP or DROP_PAR
//   write_enb_reg  out  1        FIFO write enable
//   rst_int_reg    out  1        clears the internal parity registers
//   busy           out  1        stall request to the source
//   timeout_err    out  1        one-cycle pulse when the wait times out
// -----------------------------------------------------------------------------
module router_fsm_param #(
    parameter int N_PORTS      = 3,
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 2,
    parameter int WAIT_TIMEOUT = 64,
    parameter int CNT_W        = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               pkt_valid,
    input  logic [DATA_W-1:0]  data_in,
    input  logic [N_PORTS-1:0] fifo_empty,
    input  logic               fifo_full,
    input  logic [N_PORTS-1:0] soft_reset,
    input  logic               low_pkt_valid,
    input  logic               parity_done,
    output logic [ADDR_W-1:0]  dest_addr,
    output logic               detect_add,
    output logic               lfd_state,
    output logic               ld_state,
    output logic               full_state,
    output logic               laf_state,
    output logic               drop_state,
    output logic               write_enb_reg,
    output logic               rst_int_reg,
    output logic               busy,
    output logic               timeout_err
);

    typedef enum logic [3:0] {
        DECODE       = 4'd0,
        LFD          = 4'd1,
        LOAD_DATA    = 4'd2,
        FIFO_FULL    = 4'd3,
        LAF          = 4'd4,
        LOAD_PARITY  = 4'd5,
        CHECK_PARITY = 4'd6,
        WAIT_EMPTY   = 4'd7,
        DROP         = 4'd8,
        DROP_PAR     = 4'd9
    } state_t;

    // N_PORTS may equal 2**ADDR_W, so the legality compare needs one extra bit.
    localparam logic [ADDR_W:0]  N_PORTS_L  = (ADDR_W + 1)'(N_PORTS);
    localparam bit               TIMEOUT_EN = (WAIT_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] WAIT_LAST  =
        (WAIT_TIMEOUT == 0) ? CNT_W'(0) : CNT_W'(WAIT_TIMEOUT - 1);

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   wait_cnt;
    logic [ADDR_W-1:0]  hdr_addr;
    logic               hdr_legal;
    logic               soft_hit;
    logic               timeout_hit;

    // Payload length travels with the header but is not needed for control.
    logic               unused_payload_len;
    assign unused_payload_len = ^data_in[DATA_W-1:ADDR_W];

    // Select one per-port flag by address. The address range can exceed
    // N_PORTS, so an out-of-range address simply selects 0 instead of
    // indexing past the vector.
    function automatic logic port_sel(input logic [N_PORTS-1:0] vec,
                                      input logic [ADDR_W-1:0]  idx);
        logic r;
        r = 1'b0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (idx == ADDR_W'(i)) r = vec[i];
        end
        return r;
    endfunction

    assign hdr_addr  = data_in[ADDR_W-1:0];
    assign hdr_legal = ({1'b0, hdr_addr} < N_PORTS_L);

    // Soft reset is keyed on the latched destination only. It is meaningless
    // in DECODE (no packet yet) and in the drop path (no FIFO owned).
    always_comb begin
        soft_hit = 1'b0;
        if (!(state inside {DECODE, DROP, DROP_PAR})) begin
            soft_hit = port_sel(soft_reset, dest_addr);
        end
    end

    // Next-state logic
    always_comb begin
        next_state  = state;
        timeout_hit = 1'b0;
        case (state)
            DECODE: begin
                if (pkt_valid) begin
                    if (!hdr_legal) begin
                        next_state = DROP;
                    end else if (port_sel(fifo_empty, hdr_addr)) begin
                        next_state = LFD;
                    end else begin
                        next_state = WAIT_EMPTY;
                    end
                end
            end
            WAIT_EMPTY: begin
                // A FIFO draining on the last allowed cycle still wins.
                if (port_sel(fifo_empty, dest_addr)) begin
                    next_state = LFD;
                end else if (TIMEOUT_EN && (wait_cnt == WAIT_LAST)) begin
                    next_state  = DECODE;
                    timeout_hit = 1'b1;
                end
            end
            LFD: begin
                next_state = LOAD_DATA;
            end
            LOAD_DATA: begin
                if (fifo_full) begin
                    next_state = FIFO_FULL;
                end else if (!pkt_valid) begin
                    next_state = LOAD_PARITY;
                end
            end
            FIFO_FULL: begin
                if (!fifo_full) next_state = LAF;
            end
            LAF: begin
                if (parity_done) begin
                    next_state = DECODE;
                end else if (low_pkt_valid) begin
                    next_state = LOAD_PARITY;
                end else begin
                    next_state = LOAD_DATA;
                end
            end
            LOAD_PARITY: begin
                next_state = CHECK_PARITY;
            end
            CHECK_PARITY: begin
                next_state = fifo_full ? FIFO_FULL : DECODE;
            end
            DROP: begin
                if (!pkt_valid) next_state = DROP_PAR;
            end
            DROP_PAR: begin
                // The parity byte of a dropped packet is discarded here.
                next_state = DECODE;
            end
            default: begin
                next_state = DECODE;
            end
        endcase
    end

    // State, destination, wait counter and timeout pulse registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= DECODE;
            dest_addr   <= '0;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= soft_hit ? DECODE : next_state;
            timeout_err <= timeout_hit && !soft_hit;
            if ((state == DECODE) && pkt_valid) begin
                dest_addr <= hdr_addr;
            end
            // Counts cycles already spent in WAIT_EMPTY; any other state
            // holds it at zero, so it is zero on the first waiting cycle.
            if (state == WAIT_EMPTY) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    // Moore output decodes of the registered state
    always_comb begin
        detect_add    = 1'b0;
        lfd_state     = 1'b0;
        ld_state      = 1'b0;
        full_state    = 1'b0;
        laf_state     = 1'b0;
        drop_state    = 1'b0;
        write_enb_reg = 1'b0;
        rst_int_reg   = 1'b0;
        busy          = 1'b0;
        case (state)
            DECODE: begin
                detect_add = 1'b1;
            end
            LFD: begin
                lfd_state = 1'b1;
                busy      = 1'b1;
            end
            LOAD_DATA: begin
                ld_state      = 1'b1;
                write_enb_reg = 1'b1;
            end
            FIFO_FULL: begin
                full_state = 1'b1;
                busy       = 1'b1;
            end
            LAF: begin
                laf_state     = 1'b1;
                write_enb_reg = 1'b1;
                busy          = 1'b1;
            end
            LOAD_PARITY: begin
                write_enb_reg = 1'b1;
                busy          = 1'b1;
            end
            CHECK_PARITY: begin
                rst_int_reg = 1'b1;
                busy        = 1'b1;
            end
            WAIT_EMPTY: begin
                busy = 1'b1;
            end
            DROP, DROP_PAR: begin
                // Not busy: the source streams the bad packet out.
                drop_state = 1'b1;
            end
            default: begin
                detect_add = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_router_fsm_param.sv
module tb_router_fsm_param;

    logic       clock;
    logic       reset;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic [2:0] fifo_empty;
    logic       fifo_full;
    logic [2:0] soft_reset;
    logic       low_pkt_valid;
    logic       parity_done;
    logic [1:0] dest_addr;
    logic       detect_add, lfd_state, ld_state, full_state, laf_state, drop_state;
    logic       write_enb_reg, rst_int_reg, busy, timeout_err;

    int checks   = 0;
    int failures = 0;

    router_fsm_param #(
        .N_PORTS(3), .DATA_W(8), .ADDR_W(2), .WAIT_TIMEOUT(4), .CNT_W(16)
    ) dut (
        .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full), .soft_reset(soft_reset),
        .low_pkt_valid(low_pkt_valid), .parity_done(parity_done),
        .dest_addr(dest_addr), .detect_add(detect_add), .lfd_state(lfd_state),
        .ld_state(ld_state), .full_state(full_state), .laf_state(laf_state),
        .drop_state(drop_state), .write_enb_reg(write_enb_reg),
        .rst_int_reg(rst_int_reg), .busy(busy), .timeout_err(timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Observed vector: {detect,lfd,ld,full,laf,drop,wen,rst_int,busy,terr,dest[1:0]}
    logic [11:0] obs;
    assign obs = {detect_add, lfd_state, ld_state, full_state, laf_state, drop_state,
                  write_enb_reg, rst_int_reg, busy, timeout_err, dest_addr};

    // Expected output decodes per state, bit order as in obs[11:2]
    localparam logic [9:0] E_DEC  = 10'b1000000000;
    localparam logic [9:0] E_DTO  = 10'b1000000001; // DECODE with timeout pulse
    localparam logic [9:0] E_LFD  = 10'b0100000010;
    localparam logic [9:0] E_LD   = 10'b0010001000;
    localparam logic [9:0] E_FULL = 10'b0001000010;
    localparam logic [9:0] E_LAF  = 10'b0000101010;
    localparam logic [9:0] E_LP   = 10'b0000001010;
    localparam logic [9:0] E_CP   = 10'b0000000110;
    localparam logic [9:0] E_WAIT = 10'b0000000010;
    localparam logic [9:0] E_DROP = 10'b0000010000;

    typedef struct packed {
        logic       rst;
        logic       pv;
        logic [7:0] d;
        logic [2:0] fe;
        logic       ff;
        logic [2:0] sr;
        logic       lpv;
        logic       pd;
        logic [9:0] o;
        logic [1:0] da;
    } vec_t;

    // Scoreboard: expectation pushed as a stimulus cycle is driven,
    // popped once the DUT has responded at the following edge.
    logic [11:0] sb[$];

    function automatic vec_t mk(input logic rst, input logic pv, input logic [7:0] d,
                                input logic [2:0] fe, input logic ff, input logic [2:0] sr,
                                input logic lpv, input logic pd,
                                input logic [9:0] o, input logic [1:0] da);
        vec_t v;
        v.rst = rst; v.pv = pv; v.d = d; v.fe = fe; v.ff = ff;
        v.sr = sr; v.lpv = lpv; v.pd = pd; v.o = o; v.da = da;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        reset         = v.rst;
        pkt_valid     = v.pv;
        data_in       = v.d;
        fifo_empty    = v.fe;
        fifo_full     = v.ff;
        soft_reset    = v.sr;
        low_pkt_valid = v.lpv;
        parity_done   = v.pd;
        sb.push_back({v.o, v.da});
    endtask

    task automatic test_reset();
        vec_t v[$];
        logic [11:0] e;
        v.push_back(mk(1, 0, 8'h00, 3'b111, 0, 3'b000, 0, 0, E_DEC, 2'd0));
        v.push_back(mk(1, 0, 8'h00, 3'b111, 0, 3'b000, 0, 0, E_DEC, 2'd0));
        v.push_back(mk(0, 1, 8'h0A, 3'b111, 0, 3'b000, 0, 0, E_LFD, 2'd2));
        v.push_back(mk(0, 1, 8'h11, 3'b111, 0, 3'b000, 0, 0, E_LD,  2'd2));
        v.push_back(mk(1, 1, 8'h22, 3'b111, 0, 3'b000, 0, 0, E_DEC, 2'd0));
        v.push_back(mk(1, 1, 8'h33, 3'b111, 0, 3'b000, 0, 0, E_DEC, 2'd0));
        v.push_back(mk(0, 0, 8'h00, 3'b111, 0, 3'b000, 0, 0, E_DEC, 2'd0));
        foreach (v[i]) begin
            drive(v[i]);
            @(posedge clock); #1;
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL reset step %0d: got %b required %b", i, obs, e);
            end
        end
    endtask

    task automatic test_normal_packet();
        vec_t v[$];
        logic [11:0] e;
        v.push_back(mk(0, 1, 8'h0A, 3'b111, 0, 3'b000, 0, 0, E_LFD, 2'd2));
        v.push_back(mk(0, 1, 8'h11, 3'b111, 0, 3'b000, 0, 0, E_LD,  2'd2));
        v.push_back(mk(0, 1, 8'h22, 3'b111, 0, 3'b000, 0, 0, E_LD,  2'd2));
        v.push_back(mk(0, 0, 8'h5A, 3'b111, 0, 3'b000, 0, 0, E_LP,  2'd2));
        v.push_back(mk(0, 0, 8'h00, 3'b111, 0, 3'b000, 0, 0, E_CP,  2'd2));
        v.push_back(mk(0, 0, 8'h00, 3'b111, 0, 3'b000, 0, 0, E_DEC, 2'd2));
        v.push_back(mk(0, 0, 8'h03, 3'b111, 0, 3'b000, 0, 0, E_DEC, 2'd2));
        foreach (v[i]) begin
            drive(v[i]);
            @(posedge clock); #1;
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL normal_packet step %0d: got %b required %b", i, obs, e);
            end
        end
    endtask

    task automatic test_fifo_full();
        vec_t v[$];
        logic [11:0] e;
        v.push_back(mk(0, 1, 8'h0A, 3'b111, 0, 3'b000, 0, 0, E_LFD,  2'd2));
        v.push_back(mk(0, 1, 8'h11, 3'b111, 0, 3'b000, 0, 0, E_LD,   2'd2));
        v.push_back(mk(0, 1, 8'h22, 3'b111, 1, 3'b000, 0, 0, E_FULL, 2'd2));
        v.push_back(mk(0, 1, 8'h22, 3'b111, 1, 3'b000, 0, 0, E_FULL, 2'd2));
        v.push_back(mk(0, 1, 8'h22, 3'b111, 1, 3'b000, 0, 0, E_FULL, 2'd2));
        v.push_back(mk(0, 1, 8'h22, 3'b111, 1, 3'b000, 0, 0, E_FULL, 2'd2));
        v.push_back(mk(0, 1, 8'h22, 3'b111, 0, 3'b000, 0, 0, E_LAF,  2'd2));
        v.push_back(mk(0, 1, 8'h33, 3'b111, 0, 3'b000, 0, 0, E_LD,   2'd2));
        v.push_back(mk(0, 1, 8'h44, 3'b111, 1, 3'b000, 0, 0, E_FULL, 2'd2));
        v.push_back(mk(0, 1, 8'h44, 3'b111, 0, 3'b000, 0, 0, E_LAF,  2'd2));
        v.push_back(mk(0, 0, 8'h66, 3'b111, 0, 3'b000, 1, 0, E_LP,   2'd2));
        v.push_back(mk(0, 0, 8'h00, 3'b111, 1, 3'b000, 1, 0, E_CP,   2'd2));
        v.push_back(mk(0, 0, 8'h00, 3'b111, 1, 3'b000, 1, 0, E_FULL, 2'd2));
        v.push_back(mk(0, 0, 8'h00, 3'b111, 0, 3'b000, 1, 0, E_LAF,  2'd2));
        v.push_back(mk(0, 0, 8'h00, 3'b111, 0, 3'b000, 0, 1, E_DEC,  2'd2));
        v.push_back(mk(0, 0, 8'h00, 3'b111, 0, 3'b000, 0, 0, E_DEC,  2'd2));
        foreach (v[i]) begin
            drive(v[i]);
            @(posedge clock); #1;
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL fifo_full step %0d: got %b required %b", i, obs, e);
            end
        end
    endtask

    task automatic test_drop();
        vec_t v[$];
        logic [11:0] e;
        v.push_back(mk(0, 1, 8'h07, 3'b111, 0, 3'b000, 0, 0, E_DROP, 2'd3));
        v.push_back(mk(0, 1, 8'h11, 3'b111, 0, 3'b000, 0, 0, E_DROP, 2'd3));
        v.push_back(mk(0, 1, 8'h22, 3'b111, 0, 3'b111, 0, 0, E_DROP, 2'd3));
        v.push_back(mk(0, 1, 8'h33, 3'b111, 0, 3'b000, 0, 0, E_DROP, 2'd3));
        v.push_back(mk(0, 0, 8'h44, 3'b111, 0, 3'b000, 0, 0, E_DROP, 2'd3));
        v.push_back(mk(0, 0, 8'h00, 3'b111, 0, 3'b000, 0, 0, E_DEC,  2'd3));
        v.push_back(mk(0, 0, 8'h00, 3'b111, 0, 3'b000, 0, 0, E_DEC,  2'd3));
        foreach (v[i]) begin
            drive(v[i]);
            @(posedge clock); #1;
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL drop step %0d: got %b required %b", i, obs, e);
            end
        end
    endtask

    task automatic test_wait_empty();
        vec_t v[$];
        logic [11:0] e;
        // Timeout: exactly four waiting cycles, then DECODE with a pulse
        v.push_back(mk(0, 1, 8'h01, 3'b101, 0, 3'b000, 0, 0, E_WAIT, 2'd1));
        v.push_back(mk(0, 1, 8'h01, 3'b101, 0, 3'b000, 0, 0, E_WAIT, 2'd1));
        v.push_back(mk(0, 1, 8'h01, 3'b101, 0, 3'b000, 0, 0, E_WAIT, 2'd1));
        v.push_back(mk(0, 1, 8'h01, 3'b101, 0, 3'b000, 0, 0, E_WAIT, 2'd1));
        v.push_back(mk(0, 1, 8'h01, 3'b101, 0, 3'b000, 0, 0, E_DTO,  2'd1));
        v.push_back(mk(0, 0, 8'h00, 3'b101, 0, 3'b000, 0, 0, E_DEC,  2'd1));
        // FIFO drains on the second waiting cycle
        v.push_back(mk(0, 1, 8'h01, 3'b101, 0, 3'b000, 0, 0, E_WAIT, 2'd1));
        v.push_back(mk(0, 1, 8'h01, 3'b101, 0, 3'b000, 0, 0, E_WAIT, 2'd1));
        v.push_back(mk(0, 1, 8'h01, 3'b111, 0, 3'b000, 0, 0, E_LFD,  2'd1));
        v.push_back(mk(0, 1, 8'h11, 3'b111, 0, 3'b000, 0, 0, E_LD,   2'd1));
        v.push_back(mk(0, 0, 8'h10, 3'b111, 0, 3'b000, 0, 0, E_LP,   2'd1));
        v.push_back(mk(0, 0, 8'h00, 3'b111, 0, 3'b000, 0, 0, E_CP,   2'd1));
        v.push_back(mk(0, 0, 8'h00, 3'b111, 0, 3'b000, 0, 0, E_DEC,  2'd1));
        // FIFO drains on the very last allowed cycle: empty wins over timeout
        v.push_back(mk(0, 1, 8'h01, 3'b101, 0, 3'b000, 0, 0, E_WAIT, 2'd1));
        v.push_back(mk(0, 1, 8'h01, 3'b101, 0, 3'b000, 0, 0, E_WAIT, 2'd1));
        v.push_back(mk(0, 1, 8'h01, 3'b101, 0, 3'b000, 0, 0, E_WAIT, 2'd1));
        v.push_back(mk(0, 1, 8'h01, 3'b101, 0, 3'b000, 0, 0, E_WAIT, 2'd1));
        v.push_back(mk(0, 1, 8'h01, 3'b111, 0, 3'b000, 0, 0, E_LFD,  2'd1));
        v.push_back(mk(0, 0, 8'h11, 3'b111, 0, 3'b000, 0, 0, E_LD,   2'd1));
        v.push_back(mk(0, 0, 8'h10, 3'b111, 0, 3'b000, 0, 0, E_LP,   2'd1));
        v.push_back(mk(0, 0, 8'h00, 3'b111, 0, 3'b000, 0, 0, E_CP,   2'd1));
        v.push_back(mk(0, 0, 8'h00, 3'b111, 0, 3'b000, 0, 0, E_DEC,  2'd1));
        foreach (v[i]) begin
            drive(v[i]);
            @(posedge clock); #1;
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL wait_empty step %0d: got %b required %b", i, obs, e);
            end
        end
    endtask

    task automatic test_soft_reset();
        vec_t v[$];
        logic [11:0] e;
        v.push_back(mk(0, 1, 8'h0A, 3'b111, 0, 3'b000, 0, 0, E_LFD, 2'd2));
        v.push_back(mk(0, 1, 8'h11, 3'b111, 0, 3'b000, 0, 0, E_LD,  2'd2));
        v.push_back(mk(0, 1, 8'h22, 3'b111, 0, 3'b001, 0, 0, E_LD,  2'd2));
        v.push_back(mk(0, 1, 8'h33, 3'b111, 0, 3'b010, 0, 0, E_LD,  2'd2));
        v.push_back(mk(0, 1, 8'h44, 3'b111, 0, 3'b100, 0, 0, E_DEC, 2'd2));
        v.push_back(mk(0, 0, 8'h00, 3'b111, 0, 3'b100, 0, 0, E_DEC, 2'd2));
        // Back-to-back packet to port 0 right after the soft reset
        v.push_back(mk(0, 1, 8'h04, 3'b111, 0, 3'b000, 0, 0, E_LFD, 2'd0));
        v.push_back(mk(0, 0, 8'h55, 3'b111, 0, 3'b000, 0, 0, E_LD,  2'd0));
        v.push_back(mk(0, 0, 8'h55, 3'b111, 0, 3'b000, 0, 0, E_LP,  2'd0));
        v.push_back(mk(0, 0, 8'h00, 3'b111, 0, 3'b000, 0, 0, E_CP,  2'd0));
        v.push_back(mk(0, 0, 8'h00, 3'b111, 0, 3'b000, 0, 0, E_DEC, 2'd0));
        foreach (v[i]) begin
            drive(v[i]);
            @(posedge clock); #1;
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL soft_reset step %0d: got %b required %b", i, obs, e);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; pkt_valid = 1'b0; data_in = '0; fifo_empty = 3'b111;
        fifo_full = 1'b0; soft_reset = '0; low_pkt_valid = 1'b0; parity_done = 1'b0;
        test_reset();
        test_normal_packet();
        test_fifo_full();
        test_drop();
        test_wait_empty();
        test_soft_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
